// File: rtl/npc_gen.sv
// npc_gen: next-PC generator for the fetch stage.
// Owns the architectural PC and selects the next PC from the sequential,
// branch, jump and register-indirect sources. Supports stall hold,
// exception redirect, misaligned-jr trapping and an optional single
// architectural delay slot after each taken redirect.
// Parameters must satisfy ADDR_W + SHAMT <= XLEN.
module npc_gen #(
    parameter int              XLEN       = 32,
    parameter int              ADDR_W     = 26,
    parameter int              IMM_W      = 16,
    parameter int              SHAMT      = 2,
    parameter logic [XLEN-1:0] RESET_VEC  = 32'h0040_0000,
    parameter logic [XLEN-1:0] EXC_VEC    = 32'h8000_0180,
    parameter bit              DELAY_SLOT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [1:0]        sel,
    input  logic              take,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   rs_val,
    input  logic              exc,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_seq,
    output logic [XLEN-1:0]   target,
    output logic              pending,
    output logic              misalign
);

    // One instruction word in bytes; low bits below it must be zero in a jr target.
    localparam logic [XLEN-1:0] STEP       = XLEN'(1) << SHAMT;
    localparam logic [XLEN-1:0] ALIGN_MASK = STEP - XLEN'(1);
    // Bits of pc_seq kept by a jump; all-zero when the jump field covers the full width.
    localparam logic [XLEN-1:0] UPPER_MASK = ~((XLEN'(1) << (ADDR_W + SHAMT)) - XLEN'(1));

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_JR     = 2'b11
    } sel_e;

    logic [XLEN-1:0]        pc_reg, pc_next;
    logic [XLEN-1:0]        tgt_reg, tgt_next;
    logic                   pending_reg, pending_next;
    logic                   misalign_reg, misalign_next;

    logic signed [XLEN-1:0] imm_sext;
    logic [XLEN-1:0]        br_target;
    logic [XLEN-1:0]        jump_target;
    logic                   is_redirect;
    logic                   sampled;
    logic                   bad_jr;
    logic                   taken;

    assign pc_seq      = pc_reg + STEP;
    assign imm_sext    = XLEN'($signed(imm));
    assign br_target   = pc_seq + (imm_sext << SHAMT);
    assign jump_target = (pc_seq & UPPER_MASK) | (XLEN'(addr) << SHAMT);

    // Target of whatever request is on sel this cycle, regardless of validity.
    always_comb begin
        target = pc_seq;
        case (sel_e'(sel))
            SEL_BRANCH: target = take ? br_target : pc_seq;
            SEL_JUMP:   target = jump_target;
            SEL_JR:     target = rs_val;
            default:    target = pc_seq;
        endcase
    end

    // Redirect qualification: inputs are only looked at on unstalled cycles.
    assign sampled     = redirect_valid & ~stall;
    assign is_redirect = (sel == SEL_JUMP) | (sel == SEL_JR) | ((sel == SEL_BRANCH) & take);
    // A misaligned jr traps even while a delay-slot target is queued.
    assign bad_jr      = sampled & (sel == SEL_JR) & (|(rs_val & ALIGN_MASK));
    assign taken       = sampled & is_redirect & ~pending_reg & ~bad_jr;

    // Next-PC selection in priority order: exc, bad jr, stall, pending, redirect, sequential.
    always_comb begin
        pc_next       = pc_seq;
        tgt_next      = tgt_reg;
        pending_next  = pending_reg;
        misalign_next = 1'b0;
        if (exc) begin
            pc_next      = EXC_VEC;
            pending_next = 1'b0;
        end else if (bad_jr) begin
            pc_next       = EXC_VEC;
            pending_next  = 1'b0;
            misalign_next = 1'b1;
        end else if (stall) begin
            pc_next = pc_reg;
        end else if (pending_reg) begin
            pc_next      = tgt_reg;
            pending_next = 1'b0;
        end else if (taken) begin
            if (DELAY_SLOT) begin
                pc_next      = pc_seq;
                tgt_next     = target;
                pending_next = 1'b1;
            end else begin
                pc_next = target;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg       <= RESET_VEC;
            tgt_reg      <= '0;
            pending_reg  <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            tgt_reg      <= tgt_next;
            pending_reg  <= pending_next;
            misalign_reg <= misalign_next;
        end
    end

    assign pc       = pc_reg;
    assign pending  = pending_reg;
    assign misalign = misalign_reg;

endmodule

// File: tb/tb_npc_gen.sv
// Testbench for npc_gen: one instance without and one with a delay slot,
// both driven by the same stimulus. The driver pushes hand-computed
// expectations into a scoreboard queue; a monitor pops and compares.
module tb_npc_gen;

    localparam logic [31:0] RST_V = 32'h0040_0000;
    localparam logic [31:0] EXC_V = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic        take = 1'b0;
    logic [15:0] imm = '0;
    logic [25:0] addr = '0;
    logic [31:0] rs_val = '0;
    logic        exc = 1'b0;

    logic [31:0] pc0, pc_seq0, target0, pc1, pc_seq1, target1;
    logic        pending0, misalign0, pending1, misalign1;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    typedef struct {
        string       name;
        int          d;    // 0: no-slot DUT, 1: delay-slot DUT, 2: both
        bit          ct;   // check combinational target
        logic [31:0] t;
        logic [31:0] p;
        bit          pe;
        bit          mi;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    npc_gen #(.DELAY_SLOT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .sel(sel), .take(take), .imm(imm), .addr(addr), .rs_val(rs_val), .exc(exc),
        .pc(pc0), .pc_seq(pc_seq0), .target(target0), .pending(pending0), .misalign(misalign0)
    );

    npc_gen #(.DELAY_SLOT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .sel(sel), .take(take), .imm(imm), .addr(addr), .rs_val(rs_val), .exc(exc),
        .pc(pc1), .pc_seq(pc_seq1), .target(target1), .pending(pending1), .misalign(misalign1)
    );

    task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d: got %h required %h", n, k, act, req);
        end
    endtask

    // Drive all inputs on the falling edge.
    task automatic drv(input bit r, input bit st, input bit rv, input logic [1:0] s, input bit tk,
                       input logic [15:0] im, input logic [25:0] ad, input logic [31:0] rs, input bit ex);
        @(negedge clk);
        rst = r; stall = st; redirect_valid = rv; sel = s; take = tk;
        imm = im; addr = ad; rs_val = rs; exc = ex;
    endtask

    task automatic expect_pc(input string n, input int d, input bit ct, input logic [31:0] t,
                             input logic [31:0] p, input bit pe, input bit mi);
        exp_t x;
        x.name = n; x.d = d; x.ct = ct; x.t = t; x.p = p; x.pe = pe; x.mi = mi;
        sb.push_back(x);
    endtask

    // Monitor: target just before the edge, registered outputs just after it.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.ct) begin
                    if (e.d != 1) chk({e.name, ".target"}, 0, target0, e.t);
                    if (e.d != 0) chk({e.name, ".target"}, 1, target1, e.t);
                end
                @(posedge clk);
                #1;
                if (e.d != 1) begin
                    chk({e.name, ".pc"}, 0, pc0, e.p);
                    chk({e.name, ".pending"}, 0, {31'b0, pending0}, {31'b0, e.pe});
                    chk({e.name, ".misalign"}, 0, {31'b0, misalign0}, {31'b0, e.mi});
                end
                if (e.d != 0) begin
                    chk({e.name, ".pc"}, 1, pc1, e.p);
                    chk({e.name, ".pending"}, 1, {31'b0, pending1}, {31'b0, e.pe});
                    chk({e.name, ".misalign"}, 1, {31'b0, misalign1}, {31'b0, e.mi});
                end
                txn++;
                $display("txn %0d %s: pc0=%h pc1=%h pend1=%0b", txn, e.name, pc0, pc1, pending1);
            end
        end
    end

    initial begin
        // Reset held for two cycles, then free-run.
        drv(0, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        drv(0, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("reset", 2, 0, 32'h0, RST_V, 0, 0);
        drv(1, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("seq1", 2, 1, 32'h0040_0004, 32'h0040_0004, 0, 0);
        drv(1, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("seq2", 2, 1, 32'h0040_0008, 32'h0040_0008, 0, 0);

        // No-slot instance: jump, branches, wrap cases.
        drv(0, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("reset2", 2, 0, 32'h0, RST_V, 0, 0);
        drv(1, 0, 1, 2'b10, 0, 16'h0, 26'h0100010, 32'h0, 0);
        expect_pc("jump_ds0", 0, 1, 32'h0040_0040, 32'h0040_0040, 0, 0);
        drv(1, 0, 1, 2'b01, 1, 16'hFFFE, 26'h0, 32'h0, 0);
        expect_pc("br_taken", 0, 1, 32'h0040_003C, 32'h0040_003C, 0, 0);
        drv(1, 0, 1, 2'b10, 0, 16'h0, 26'h0100010, 32'h0, 0);
        expect_pc("jump_back", 0, 1, 32'h0040_0040, 32'h0040_0040, 0, 0);
        drv(1, 0, 1, 2'b01, 0, 16'hFFFE, 26'h0, 32'h0, 0);
        expect_pc("br_not_taken", 0, 1, 32'h0040_0044, 32'h0040_0044, 0, 0);
        drv(1, 0, 0, 2'b10, 0, 16'h0, 26'h0100010, 32'h0, 0);
        expect_pc("valid_low", 0, 1, 32'h0040_0040, 32'h0040_0048, 0, 0);
        drv(1, 0, 1, 2'b11, 0, 16'h0, 26'h0, 32'h0040_0042, 0);
        expect_pc("jr_misalign", 2, 1, 32'h0040_0042, EXC_V, 0, 1);
        drv(1, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("misalign_clr", 2, 1, 32'h8000_0184, 32'h8000_0184, 0, 0);
        drv(1, 0, 1, 2'b11, 0, 16'h0, 26'h0, 32'hFFFF_FFFC, 0);
        expect_pc("jr_top", 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0);
        drv(1, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("seq_wrap", 0, 1, 32'h0000_0000, 32'h0000_0000, 0, 0);
        drv(1, 0, 1, 2'b11, 0, 16'h0, 26'h0, 32'hFFFF_FFF8, 0);
        expect_pc("jr_top2", 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 0, 0);
        drv(1, 0, 1, 2'b01, 1, 16'h0002, 26'h0, 32'h0, 0);
        expect_pc("br_wrap", 0, 1, 32'h0000_0004, 32'h0000_0004, 0, 0);
        drv(1, 0, 1, 2'b10, 0, 16'h0, 26'h0100010, 32'h0, 1);
        expect_pc("exc_vs_redirect", 2, 0, 32'h0, EXC_V, 0, 0);
        drv(1, 1, 1, 2'b11, 0, 16'h0, 26'h0, 32'h0040_0042, 0);
        expect_pc("stall_bad_jr", 2, 0, 32'h0, EXC_V, 0, 0);
        drv(1, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("seq_exc", 2, 0, 32'h0, 32'h8000_0184, 0, 0);
        drv(1, 1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 1);
        expect_pc("exc_stall", 2, 0, 32'h0, EXC_V, 0, 0);

        // Delay-slot instance.
        drv(0, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("reset3", 2, 0, 32'h0, RST_V, 0, 0);
        drv(1, 0, 1, 2'b10, 0, 16'h0, 26'h0100010, 32'h0, 0);
        expect_pc("jump_ds1", 1, 1, 32'h0040_0040, 32'h0040_0004, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
            expect_pc("slot_stall", 1, 0, 32'h0, 32'h0040_0004, 1, 0);
        end
        drv(1, 0, 1, 2'b10, 0, 16'h0, 26'h0000100, 32'h0, 0);
        expect_pc("slot_ignore", 1, 1, 32'h0000_0400, 32'h0040_0040, 0, 0);
        drv(1, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("after_slot", 1, 1, 32'h0040_0044, 32'h0040_0044, 0, 0);
        drv(1, 0, 1, 2'b10, 0, 16'h0, 26'h0100010, 32'h0, 0);
        expect_pc("jump_ds1b", 1, 1, 32'h0040_0040, 32'h0040_0048, 1, 0);
        drv(1, 1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 1);
        expect_pc("exc_stall_pend", 1, 0, 32'h0, EXC_V, 0, 0);
        drv(1, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("exc_drop", 1, 1, 32'h8000_0184, 32'h8000_0184, 0, 0);
        drv(1, 0, 1, 2'b10, 0, 16'h0, 26'h0100010, 32'h0, 0);
        expect_pc("jump_ds1c", 1, 1, 32'h8040_0040, 32'h8000_0188, 1, 0);
        drv(0, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("reset_mid", 1, 0, 32'h0, RST_V, 0, 0);
        drv(1, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        expect_pc("reset_drop", 1, 1, 32'h0040_0004, 32'h0040_0004, 0, 0);
        drv(1, 0, 1, 2'b10, 0, 16'h0, 26'h0100010, 32'h0, 0);
        expect_pc("jump_ds1d", 1, 1, 32'h0040_0040, 32'h0040_0008, 1, 0);
        drv(1, 0, 1, 2'b11, 0, 16'h0, 26'h0, 32'h0040_0042, 0);
        expect_pc("bad_jr_pend", 1, 1, 32'h0040_0042, EXC_V, 0, 1);

        // Drain the scoreboard with a bounded wait.
        drv(1, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 0);
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/npc_gen.md
# npc_gen

Parametrised next-PC generator for the MIPS fetch stage and the successor to the combinational shift-left-2 jump-address aggregator. It owns the architectural PC register and selects the next PC each cycle from four sources: sequential, conditional branch, jump-aggregate and register-indirect. It adds stall hold, an exception redirect, misaligned-target trapping and an optional branch-delay-slot mode. It sits between the decode/branch-resolve logic and the instruction memory address port.

## Interface
- XLEN, 32: PC and data width.
- ADDR_W, 26: jump-index field width.
- IMM_W, 16: branch immediate width, sign-extended.
- SHAMT, 2: word-offset shift; legal when ADDR_W+SHAMT <= XLEN.
- RESET_VEC, 32'h0040_0000: PC loaded on reset.
- EXC_VEC, 32'h8000_0180: PC loaded on exception or misaligned indirect target.
- DELAY_SLOT, 0: 1 enables one architectural delay slot after each taken redirect.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- stall  in  1  hold PC and pending state; redirect inputs are not sampled.
- redirect_valid  in  1  sel and its operands are valid this cycle.
- sel  in  2  00 sequential, 01 branch, 10 jump, 11 jr.
- take  in  1  branch condition; used only when sel=01.
- imm  in  IMM_W  branch offset in words.
- addr  in  ADDR_W  jump index.
- rs_val  in  XLEN  jr target.
- exc  in  1  exception request.
- pc  out  XLEN  current PC, registered.
- pc_seq  out  XLEN  pc + (1<<SHAMT), combinational.
- target  out  XLEN  target of the current request, combinational.
- pending  out  1  a delay-slot redirect is queued, registered.
- misalign  out  1  one-cycle pulse: a jr target was misaligned, registered.

## Operation
- Target computation. All arithmetic is modulo 2^XLEN and wraps silently.
  - Branch: pc_seq + (sext(imm) << SHAMT).
  - Jump: {pc_seq[XLEN-1:ADDR_W+SHAMT], addr, SHAMT'b0}. The upper bits come from pc_seq, not pc.
  - jr: rs_val.
  - Sequential, or branch with take=0: target = pc_seq.
- A redirect is "taken" when all of the following hold:
  - redirect_valid=1 and stall=0;
  - sel=10, sel=11, or (sel=01 and take=1);
  - pending=0.
- A redirect that arrives while pending=1 is ignored, and the queued target wins.
- jr with rs_val[SHAMT-1:0] != 0 is never taken as a normal redirect. It loads EXC_VEC, pulses misalign, and clears pending.
- Next-PC priority, highest first:
  1. reset;
  2. exc;
  3. misaligned jr;
  4. stall (hold);
  5. pending (load the queued target);
  6. taken redirect;
  7. pc_seq.
- DELAY_SLOT=0: a taken redirect loads the target directly.
- DELAY_SLOT=1: a taken redirect loads pc_seq, captures the target into an internal register, and sets pending. On the next unstalled cycle pc takes the captured target and pending clears.
- exc overrides stall and clears pending.

## Timing
- Reset (rst=0 at posedge) sets pc=RESET_VEC, pending=0, misalign=0, and clears the captured target.
- Reset asserted mid-delay-slot discards the queued target.
- Redirect latency:
  - DELAY_SLOT=0: 1 cycle (pc equals the target at the next posedge).
  - DELAY_SLOT=1: 2 unstalled cycles.
- stall=1 holds pc, pending and the captured target for any number of cycles. misalign is 0 while stalled.
- misalign is high for exactly the cycle after the offending jr is sampled.
- exc and a taken redirect in the same cycle: exc wins and the redirect is dropped.
- exc and stall in the same cycle: pc=EXC_VEC at the next posedge.
- pc_seq and target settle combinationally from pc and the inputs in the same cycle. No path runs from the inputs to pc without a register.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release -> pc=0x00400000, pending=0, misalign=0; free-running sequence 0x00400004, 0x00400008.
- Jump, DELAY_SLOT=0: at pc=0x00400000, sel=10, addr=26'h0100010 -> target=0x00400040, and pc=0x00400040 at the next posedge.
- Branch: at pc=0x00400040, sel=01, imm=16'hFFFE, take=1 -> next pc=0x0040003C. The same case with take=0 -> 0x00400044.
- Delay slot, DELAY_SLOT=1, same jump as above:
  - next pc=0x00400004 with pending=1;
  - stall for 3 cycles: pc and pending hold;
  - a second jump is presented during the slot and ignored;
  - then pc=0x00400040 with pending=0.
- jr: rs_val=0x00400042 -> pc=0x80000180 and misalign=1 for one cycle. Separately, exc=1 with stall=1 while pending=1 -> pc=0x80000180 and pending=0.
- Wrap: jr to 0xFFFFFFFC, then a sequential cycle -> pc=0x00000000. A branch from pc=0xFFFFFFF8 with imm=16'h0002 -> pc=0x00000004.
